pulse_req_queue: RTL and testbench

PULSE_REQ_QUEUE -- requirements
Module: pulse_req_queue

---
 rtl/pulse_req_queue_if.sv | 26 ++
 rtl/pulse_req_queue.sv | 85 ++++++++
 tb/tb_pulse_req_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_req_queue_if.sv
// Handshake bundle between the event source, the pulse queue and the
// downstream fast-to-slow pulse synchronizer.
interface pulse_req_queue_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             sync_busy;
    logic             clr_ovf;
    logic             sig_out;
    logic [CNT_W-1:0] pending;
    logic             ovf;
    logic             busy_err;
    logic             idle;

    // Source/synchronizer side: drives requests and busy, observes the queue.
    modport master (
        output evt_in, sync_busy, clr_ovf,
        input  sig_out, pending, ovf, busy_err, idle
    );

    // Queue side.
    modport slave (
        input  evt_in, sync_busy, clr_ovf,
        output sig_out, pending, ovf, busy_err, idle
    );
endinterface

// File: rtl/pulse_req_queue.sv
// Pulse request queue: counts incoming events and issues them one at a time
// as single-cycle pulses to a fast-to-slow pulse synchronizer, waiting for
// the synchronizer's busy flag to rise and fall between pulses.
module pulse_req_queue #(
    parameter int CNT_W = 4
) (
    input  logic               clk_a,
    input  logic               rst,
    pulse_req_queue_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pending;
    logic             sig_q;
    logic             ovf_q;
    logic             busy_err_q;
    logic             issue;
    logic             sat_drop;

    // The ISSUE cycle is the one that consumes a queued event.
    assign issue    = (state == ISSUE);
    // An event arriving at saturation is dropped unless the issue frees a slot.
    assign sat_drop = bus.evt_in && !issue && (pending == PEND_MAX);

    // State register.
    always_ff @(posedge clk_a or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pending != '0 && !bus.sync_busy) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: state_nxt = bus.sync_busy ? WAIT_DONE : IDLE;
            WAIT_DONE: if (!bus.sync_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // sig_out comes straight from a flop that mirrors entry into ISSUE.
    always_ff @(posedge clk_a or negedge rst) begin
        if (!rst) sig_q <= 1'b0;
        else      sig_q <= (state_nxt == ISSUE);
    end

    // Pending counter: +1 per event, -1 per issue, saturating at the top.
    always_ff @(posedge clk_a or negedge rst) begin
        if (!rst)
            pending <= '0;
        else if (bus.evt_in && !issue && !sat_drop)
            pending <= pending + 1'b1;
        else if (!bus.evt_in && issue)
            pending <= pending - 1'b1;
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk_a or negedge rst) begin
        if (!rst)             ovf_q <= 1'b0;
        else if (sat_drop)    ovf_q <= 1'b1;
        else if (bus.clr_ovf) ovf_q <= 1'b0;
    end

    // Sticky error when the synchronizer never acknowledged a pulse.
    always_ff @(posedge clk_a or negedge rst) begin
        if (!rst)                                      busy_err_q <= 1'b0;
        else if (state == WAIT_BUSY && !bus.sync_busy) busy_err_q <= 1'b1;
    end

    assign bus.sig_out  = sig_q;
    assign bus.pending  = pending;
    assign bus.ovf      = ovf_q;
    assign bus.busy_err = busy_err_q;
    assign bus.idle     = (state == IDLE) && (pending == '0);
endmodule

// File: tb/tb_pulse_req_queue.sv
// Self-checking bench for pulse_req_queue: a cycle reference model of the
// queue, a per-cycle output comparator, directed scenarios and random traffic.
module tb_pulse_req_queue;
    localparam int CNT_W    = 4;
    localparam int MAXP     = (1 << CNT_W) - 1;
    localparam int BUSY_LEN = 6;

    logic clk_a = 1'b0;
    logic rst   = 1'b0;

    pulse_req_queue_if #(.CNT_W(CNT_W)) bus ();

    pulse_req_queue #(.CNT_W(CNT_W)) dut (
        .clk_a (clk_a),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_a = ~clk_a;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=waiting for work, 1=pulse cycle,
    // 2=expecting ack, 3=ack held.
    int m_pend, m_phase, m_next;
    bit m_ovf, m_berr;

    always @(posedge clk_a or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_phase = 0; m_ovf = 0; m_berr = 0;
        end else begin
            m_next = m_pend + (bus.evt_in ? 1 : 0) - (m_phase == 1 ? 1 : 0);
            if (m_next > MAXP) begin
                m_next = MAXP;
                m_ovf  = 1;
            end else if (bus.clr_ovf) begin
                m_ovf = 0;
            end
            case (m_phase)
                0: if (m_pend > 0 && !bus.sync_busy) m_phase = 1;
                1: m_phase = 2;
                2: if (bus.sync_busy) m_phase = 3;
                   else begin m_phase = 0; m_berr = 1; end
                default: if (!bus.sync_busy) m_phase = 0;
            endcase
            m_pend = m_next;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_a) begin
        chk("sig_out",  int'(bus.sig_out),  (m_phase == 1) ? 1 : 0);
        chk("pending",  int'(bus.pending),  m_pend);
        chk("ovf",      int'(bus.ovf),      int'(m_ovf));
        chk("busy_err", int'(bus.busy_err), int'(m_berr));
        chk("idle",     int'(bus.idle),     (m_phase == 0 && m_pend == 0) ? 1 : 0);
    end

    // Downstream synchronizer model: 0=well behaved, 1=busy forced high,
    // 2=busy tied low, 3=random ack length with occasional missing ack.
    int mode   = 0;
    int bcnt   = 0;
    bit prev_s = 0;
    int pulses = 0;

    task automatic tick();
        @(negedge clk_a);
        if (bus.sig_out) pulses++;
        case (mode)
            0: if (prev_s) bcnt = BUSY_LEN;
            2: bcnt = 0;
            3: if (prev_s) bcnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            default: ;
        endcase
        if (mode == 1) bus.sync_busy = 1'b1;
        else begin
            bus.sync_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end
        prev_s = bus.sig_out;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.idle && !bus.sync_busy && bcnt == 0) begin ok = 1; break; end
        end
        chk("wait_idle_timeout", int'(ok), 1);
    endtask

    initial begin
        bus.evt_in = 0; bus.sync_busy = 0; bus.clr_ovf = 0;
        rst = 0;
        repeat (3) tick();
        // Reset state
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_idle",    int'(bus.idle),    1);
        chk("rst_sig",     int'(bus.sig_out), 0);
        chk("rst_ovf",     int'(bus.ovf),     0);
        chk("rst_berr",    int'(bus.busy_err), 0);
        #2 rst = 1;
        tick();

        // Single event latency
        mode = 0;
        bus.evt_in = 1; tick(); bus.evt_in = 0;
        chk("single_c1_pending", int'(bus.pending), 1);
        chk("single_c1_sig",     int'(bus.sig_out), 0);
        tick();
        chk("single_c2_sig",     int'(bus.sig_out), 1);
        tick();
        chk("single_c3_sig",     int'(bus.sig_out), 0);
        chk("single_c3_pending", int'(bus.pending), 0);
        wait_idle(50);

        // Burst of three with a well-behaved downstream
        pulses = 0;
        repeat (3) begin bus.evt_in = 1; tick(); end
        bus.evt_in = 0;
        wait_idle(100);
        chk("burst_pulses", pulses, 3);
        chk("burst_idle",   int'(bus.idle), 1);

        // Saturation while downstream busy
        mode = 1; tick();
        repeat (17) begin bus.evt_in = 1; tick(); end
        bus.evt_in = 0;
        chk("sat_pending", int'(bus.pending), MAXP);
        chk("sat_ovf",     int'(bus.ovf), 1);
        mode = 0; pulses = 0;
        wait_idle(400);
        chk("sat_pulses", pulses, MAXP);
        bus.clr_ovf = 1; tick(); bus.clr_ovf = 0;
        chk("clr_ovf", int'(bus.ovf), 0);

        // Event on the issue cycle with two queued
        wait_idle(50);
        mode = 1; tick();
        repeat (2) begin bus.evt_in = 1; tick(); end
        bus.evt_in = 0;
        chk("simul_pre_pending", int'(bus.pending), 2);
        mode = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (bus.sig_out) break; end
        chk("simul_issue_seen", int'(bus.sig_out), 1);
        bus.evt_in = 1; tick(); bus.evt_in = 0;
        chk("simul_pending", int'(bus.pending), 2);
        wait_idle(200);

        // Broken downstream: busy never rises
        mode = 2; pulses = 0;
        repeat (2) begin bus.evt_in = 1; tick(); end
        bus.evt_in = 0;
        repeat (30) tick();
        chk("broken_pulses", pulses, 2);
        chk("broken_berr",   int'(bus.busy_err), 1);
        chk("broken_idle",   int'(bus.idle), 1);

        // Reset while waiting for busy to drop, with five queued
        mode = 0; tick();
        repeat (6) begin bus.evt_in = 1; tick(); end
        bus.evt_in = 0;
        chk("rstmid_pending_before", int'(bus.pending), 5);
        #2 rst = 0;
        #1;
        chk("rstmid_sig",     int'(bus.sig_out), 0);
        chk("rstmid_pending", int'(bus.pending), 0);
        chk("rstmid_idle",    int'(bus.idle), 1);
        tick(); tick();
        #2 rst = 1;
        pulses = 0;
        repeat (20) tick();
        chk("rstmid_no_pulse", pulses, 0);
        chk("rstmid_berr",     int'(bus.busy_err), 0);

        // Random traffic against the model
        mode = 3;
        for (int blk = 0; blk < 12; blk++) begin
            int rate = int'($urandom_range(1, 9));
            for (int c = 0; c < 250; c++) begin
                bus.evt_in  = ($urandom_range(0, 9) < rate);
                bus.clr_ovf = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        bus.evt_in = 0; bus.clr_ovf = 0;
        mode = 0;
        wait_idle(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
